// File: rtl/leftpad_collect.sv
// leftpad_collect
// Collects the serial character stream coming out of the leftpad core and
// packs it into one string. The stream length is checked against the length
// the core should produce, and the result is handed to the consumer through a
// valid/ready handshake.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active low
//   start      arm pulse, accepted in IDLE, or in DONE together with res_ready
//   exp_len    expected stream length, latched on an accepted start
//   in_char    character from the leftpad core (cout)
//   in_en      in_char is valid (leftpad out_en)
//   busy       frame in progress (WAIT, CAPT, CHK)
//   res_valid  result available, outputs held stable until res_ready
//   res_ready  consumer takes the result
//   res_str    packed result, char i at [i*CHAR_W +: CHAR_W], unfilled slots 0
//   res_len    number of characters captured
//   res_err    [0] gap, [1] overflow, [2] timeout
//
// state | meaning
// IDLE  | no frame, waiting for start
// WAIT  | armed, waiting for the first character, timer running
// CAPT  | receiving characters, a gap ends the frame with an error
// CHK   | one cycle after the last expected character, catches an overflow
// DONE  | result presented, waiting for res_ready
module leftpad_collect #(
  parameter int STR_LEN_MAX = 8,
  parameter int CHAR_W      = 8,
  parameter int TIMEOUT     = 3*STR_LEN_MAX,
  localparam int LEN_W      = $clog2(2*STR_LEN_MAX)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_W-1:0]                exp_len,
  input  logic [CHAR_W-1:0]               in_char,
  input  logic                            in_en,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [2*STR_LEN_MAX*CHAR_W-1:0] res_str,
  output logic [LEN_W-1:0]                res_len,
  output logic [2:0]                      res_err
);

  localparam int TMR_W = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    CAPT = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  exp_q;
  logic [TMR_W-1:0]  timer;
  logic              start_acc;
  logic [LEN_W-1:0]  cnt_inc;

  // In DONE a start only counts when the handshake completes in the same cycle,
  // so a pending result is never overwritten.
  assign start_acc = start & ((state == IDLE) | ((state == DONE) & res_ready));

  // res_len doubles as the capture count / write index; it never exceeds
  // exp_q, so the increment cannot wrap.
  assign cnt_inc = res_len + LEN_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      exp_q     <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_str   <= '0;
      res_len   <= '0;
      res_err   <= '0;
    end else if (start_acc) begin
      exp_q     <= exp_len;
      timer     <= '0;
      res_str   <= '0;
      res_len   <= '0;
      res_err   <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b1;
      state     <= (exp_len == '0) ? CHK : WAIT;
    end else begin
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end

        WAIT: begin
          if (in_en) begin
            res_str[CHAR_W-1:0] <= in_char;
            res_len             <= LEN_W'(1);
            state               <= (exp_q == LEN_W'(1)) ? CHK : CAPT;
          end else if (timer == TMR_W'(TIMEOUT-1)) begin
            res_err[2] <= 1'b1;
            busy       <= 1'b0;
            res_valid  <= 1'b1;
            state      <= DONE;
          end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
          end
        end

        CAPT: begin
          if (in_en) begin
            res_str[int'(res_len)*CHAR_W +: CHAR_W] <= in_char;
            res_len <= cnt_inc;
            if (cnt_inc == exp_q) begin
              state <= CHK;
            end
          end else begin
            // out_en from the core is contiguous, so any hole is a fault
            res_err[0] <= 1'b1;
            busy       <= 1'b0;
            res_valid  <= 1'b1;
            state      <= DONE;
          end
        end

        CHK: begin
          // a character here is one too many; it is flagged and dropped
          if (in_en) begin
            res_err[1] <= 1'b1;
          end
          busy      <= 1'b0;
          res_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          busy      <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leftpad_collect.sv
// Testbench for leftpad_collect. Each frame is described by expected length,
// idle delay before the first character and number of contiguous characters;
// a reference model derives result, error flags and latency from those.
module tb_leftpad_collect;

  localparam int SLM = 8;
  localparam int CW  = 8;
  localparam int TO  = 3*SLM;
  localparam int LW  = $clog2(2*SLM);
  localparam int SW  = 2*SLM*CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] exp_len = '0;
  logic [CW-1:0] in_char = '0;
  logic          in_en = 1'b0;
  logic          busy;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [SW-1:0] res_str;
  logic [LW-1:0] res_len;
  logic [2:0]    res_err;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] stim [32];
  logic [SW-1:0] e_str;
  int            e_len;
  logic [2:0]    e_err;
  int            e_lat;

  leftpad_collect #(.STR_LEN_MAX(SLM), .CHAR_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_len(exp_len),
    .in_char(in_char), .in_en(in_en), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_str(res_str), .res_len(res_len), .res_err(res_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic load_str(input string s);
    for (int i = 0; i < 32; i++) stim[i] = '0;
    for (int i = 0; i < s.len(); i++) stim[i] = s[i];
  endtask

  task automatic load_rand();
    for (int i = 0; i < 32; i++) stim[i] = CW'($urandom_range(1, 255));
  endtask

  // Result of a frame from its description alone.
  task automatic model(input int exp, input int d, input int n);
    e_str = '0;
    if (exp == 0) begin
      e_len = 0;
      e_err = (d == 0 && n > 0) ? 3'b010 : 3'b000;
      e_lat = 2;
    end else if (n == 0 || d >= TO) begin
      e_len = 0;
      e_err = 3'b100;
      e_lat = TO + 1;
    end else if (n < exp) begin
      e_len = n;
      e_err = 3'b001;
      e_lat = d + n + 2;
    end else begin
      e_len = exp;
      e_err = (n > exp) ? 3'b010 : 3'b000;
      e_lat = d + exp + 2;
    end
    for (int i = 0; i < e_len; i++) e_str[i*CW +: CW] = stim[i];
  endtask

  // Start in cycle 0 (with res_ready, so a pending result is handed over),
  // then d idle cycles, then n characters from stim. Ends with res_valid seen.
  task automatic run_frame(input string nm, input int exp, input int d, input int n);
    int lat;
    model(exp, d, n);
    lat = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      start     = (c == 0);
      res_ready = (c == 0);
      exp_len   = LW'(exp);
      in_en     = (c >= d + 1) && (c <= d + n);
      if (in_en) in_char = stim[c-d-1];
      else       in_char = CW'($urandom);
      @(posedge clk);
      #1;
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b need 1", nm, busy);
        end
      end
      if (res_valid === 1'b1) begin
        lat = c + 1;
        break;
      end
    end
    start = 1'b0; in_en = 1'b0; res_ready = 1'b0;
    checks++;
    if (lat !== e_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d need %0d", nm, lat, e_lat);
    end
    checks++;
    if (res_str !== e_str) begin
      errors++;
      $display("FAIL %s res_str: got %h need %h", nm, res_str, e_str);
    end
    checks++;
    if (res_len !== LW'(e_len)) begin
      errors++;
      $display("FAIL %s res_len: got %0d need %0d", nm, res_len, e_len);
    end
    checks++;
    if (res_err !== e_err) begin
      errors++;
      $display("FAIL %s res_err: got %b need %b", nm, res_err, e_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b need 0", nm, busy);
    end
  endtask

  task automatic release_result(input string nm);
    @(negedge clk);
    res_ready = 1'b1;
    in_en = 1'b1;
    in_char = CW'($urandom);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    in_en = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b busy=%b need 0 0", nm, res_valid, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, res_valid, res_len, res_err} !== '0 || res_str !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b len=%0d err=%b str=%h need all 0",
               busy, res_valid, res_len, res_err, res_str);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_foo();
    load_str("!!foo");
    run_frame("foo", 5, 0, 5);
    release_result("foo");
  endtask

  task automatic test_zero_len();
    load_rand();
    run_frame("zero_len", 0, 3, 0);
    release_result("zero_len");
    run_frame("zero_len_ovf", 0, 0, 2);
    release_result("zero_len_ovf");
  endtask

  task automatic test_gap();
    load_str("!!f");
    run_frame("gap", 5, 0, 3);
    release_result("gap");
  endtask

  task automatic test_overflow();
    load_str("abcd");
    run_frame("overflow", 3, 0, 4);
    release_result("overflow");
  endtask

  task automatic test_timeout();
    load_rand();
    run_frame("timeout", 4, 0, 0);
    release_result("timeout");
    run_frame("timeout_edge_late", 4, TO, 4);
    release_result("timeout_edge_late");
    run_frame("timeout_edge_ok", 4, TO - 1, 4);
    release_result("timeout_edge_ok");
    run_frame("max_len", 2*SLM - 1, 1, 2*SLM - 1);
    release_result("max_len");
    run_frame("one_char", 1, 2, 1);
    release_result("one_char");
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en = 1'b1;
      in_char = CW'($urandom);
    end
    @(negedge clk);
    in_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_noise: got busy=%b valid=%b need 0 0", busy, res_valid);
    end
    load_rand();
    run_frame("after_noise", 3, 0, 3);
    release_result("after_noise");
  endtask

  task automatic test_backpressure();
    load_str("hello");
    run_frame("bp_first", 5, 1, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      res_ready = 1'b0;
      start = (i % 3 == 0);
      exp_len = LW'(7);
      in_en = 1'b1;
      in_char = CW'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_str !== e_str || res_len !== LW'(e_len) || res_err !== e_err) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b len=%0d err=%b str=%h need 1 %0d %b %h",
                 i, res_valid, res_len, res_err, res_str, e_len, e_err, e_str);
      end
    end
    start = 1'b0; in_en = 1'b0;
    load_str("xy");
    run_frame("back_to_back", 2, 0, 2);
    release_result("back_to_back");
  endtask

  task automatic test_random();
    int exp, d, n, sel;
    for (int k = 0; k < 30; k++) begin
      load_rand();
      exp = $urandom_range(0, 2*SLM - 1);
      sel = $urandom_range(0, 9);
      d = (sel == 9) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      case (sel)
        0: n = exp;
        1: n = exp + $urandom_range(1, 2);
        2: n = (exp > 0) ? $urandom_range(0, exp - 1) : 0;
        default: n = exp;
      endcase
      run_frame("random", exp, d, n);
      release_result("random");
    end
  endtask

  task automatic test_reset_mid();
    load_rand();
    @(negedge clk);
    start = 1'b1; exp_len = LW'(6); in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      in_en = 1'b1;
      in_char = stim[i];
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, res_len, res_err} !== '0 || res_str !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b valid=%b len=%0d err=%b str=%h need all 0",
               busy, res_valid, res_len, res_err, res_str);
    end
    @(negedge clk);
    in_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got busy=%b valid=%b need 0 0", busy, res_valid);
    end
    load_rand();
    run_frame("after_reset", 4, 1, 4);
    release_result("after_reset");
  endtask

  initial begin
    test_reset();
    test_foo();
    test_zero_len();
    test_gap();
    test_overflow();
    test_timeout();
    test_idle_noise();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
